dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Data-memory access controller between the single-cycle `xgriscv_sc` core's load/store port and a debug/program-loader port. It shares one single-port, word-wide, synchronous-read data RAM between the two requesters. It also performs RISC-V sub-word formatting: byte-enable generation and store-data replication for SB/SH/SW, and shift plus sign/zero-extension for LB/LH/LW/LBU/LHU. Each access is sequenced through a small state machine with a request/acknowledge handshake.

## Interface
- `MEM_AW`, 10: word-address width of the RAM (1024 words).
- `clk`  in  1  system clock, rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `c_req`  in  1  CPU request; held high until `c_ack`.
- `c_we`  in  1  CPU store (1) / load (0).
- `c_addr`  in  32  CPU byte address.
- `c_size`  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `c_wdata`  in  32  CPU store data, right-aligned.
- `c_ack`  out  1  one-cycle completion pulse.
- `c_rdata`  out  32  formatted load data; valid while `c_ack`=1.
- `c_err`  out  1  misaligned/illegal flag, qualified by `c_ack`.
- `d_req`, `d_we`, `d_addr`, `d_size`, `d_wdata`, `d_ack`, `d_rdata`, `d_err`: loader port with identical meaning.
- `mem_en`  out  1  RAM access strobe.
- `mem_we`  out  4  RAM byte write enables.
- `mem_addr`  out  MEM_AW  word address, equal to `addr[MEM_AW+1:2]`.
- `mem_wdata`  out  32  RAM write data.
- `mem_rdata`  in  32  RAM read data, valid one cycle after `mem_en` with `mem_we`=0.

## Operation
- The state machine has three states: IDLE, ACCESS and RESP.
- **IDLE**
  - If any `req` is high, select a winner, register its `we`, `addr`, `size` and `wdata`, and go to ACCESS.
  - Otherwise stay in IDLE.
- **ACCESS**
  - Drive `mem_en`=1, `mem_addr`, `mem_we` (store only, else 0) and `mem_wdata`. Go to RESP.
- **RESP**
  - Pulse the winner's `ack`.
  - For loads, the winner's `rdata` is the formatted `mem_rdata`.
  - Go to IDLE.
  - Both `req` inputs are ignored in RESP.
- **Arbitration**: round-robin over a 1-bit `last_grant` register.
  - A sole requester always wins.
  - If both request, the port not granted last wins.
  - `last_grant` updates on each grant.
  - Reset value is the loader, so the CPU wins the first tie.
- **Store formatting**
  - Byte: `mem_we = 0001 << addr[1:0]`, data `{4{wdata[7:0]}}`.
  - Half: `mem_we = 0011 << (2*addr[1])`, data `{2{wdata[15:0]}}`.
  - Word: `mem_we = 1111`, data `wdata`.
- **Load formatting**
  - Compute `mem_rdata >> (8*addr[1:0])`.
  - B/H are sign-extended from bit 7/15; BU/HU are zero-extended; W passes through.
- **Illegal sizes and misalignment**
  - `size` values 011, 110 and 111 are handled as W.
  - Misalignment (macro off): address low bits are ignored. H ignores `addr[0]`; W ignores `addr[1:0]`.
- Non-acked `rdata` outputs hold their last value.

## Timing
- Reset drives all outputs to 0, the state to IDLE and `last_grant` to loader, immediately and regardless of state. An access in flight is dropped with no `ack`.
- Latency: if `req` is sampled high in IDLE at edge N, `mem_en` is high in cycle N+1 and `ack` is high in cycle N+2.
- One access per 3 cycles; no back-to-back issue.
- The requester must hold all of its inputs stable from `req` until `ack`, and deassert or re-present on the edge after `ack`.
- The two `ack` signals are never high in the same cycle.
- A `req` rising during ACCESS or RESP is served at the next IDLE.

## Configuration
- Macro: `DMEM_MISALIGN_TRAP_EN`.
- **Defined**
  - H with `addr[0]`=1, W with `addr[1:0]`≠0, and `size` values 011/110/111 complete without any RAM access.
  - In ACCESS, `mem_en`=0. In RESP, `ack`=1, `err`=1 and `rdata`=0.
  - Aligned accesses behave as with the macro undefined.
- **Undefined**
  - Low address bits are ignored as in Operation, and `err` is tied to 0.

## Structure
- Shared package `xgriscv_pkg`:
  - funct3 load/store size constants (`SZ_B`, `SZ_H`, `SZ_W`, `SZ_BU`, `SZ_HU`);
  - state encoding (`DM_IDLE`, `DM_ACCESS`, `DM_RESP`);
  - port-id constants (`PORT_CPU`, `PORT_DBG`).
- One sub-module, `dmem_ld_align`: combinational shift and sign/zero-extension taking `mem_rdata`, `addr[1:0]` and `size` to `rdata`.

## Test plan
- **Aligned SW**: reset, then CPU SW `addr`=0x10, `wdata`=0xF1F2F3F4 → cycle+1: `mem_en`=1, `mem_we`=1111, `mem_addr`=4; cycle+2: `c_ack`=1, `c_err`=0.
- **SB lane select**: CPU SB `addr`=0x11, `wdata`=0x000000A5 → `mem_we`=0010, `mem_wdata`=0xA5A5A5A5.
- **Load formatting**, with `mem_rdata`=0xF1F2F3F4:
  - LB @0x13 → 0xFFFFFFF1;
  - LBU @0x13 → 0x000000F1;
  - LH @0x10 → 0xFFFFF3F4;
  - LHU @0x12 → 0x0000F1F2.
- **Round-robin**: both requesters held high from reset → `c_ack` at cycle 2, `d_ack` at cycle 5, `c_ack` at cycle 8; `acks` never coincide.
- **Misaligned LW @0x06**:
  - macro off → `mem_addr`=1, `c_rdata`=`mem_rdata`;
  - macro on → `mem_en` stays 0, `c_ack`=1 with `c_err`=1 and `c_rdata`=0.
- **Reset mid-access**: `rstn` low during ACCESS → all outputs 0 asynchronously, no `ack`. After release with `c_req` still high → fresh grant, and `ack` 2 cycles after IDLE sampling.

Source files
------------

// File: rtl/xgriscv_pkg.sv
// Shared definitions for the xgriscv_sc data-memory path: access sizes, arbiter
// state encoding, port ids and size-decoding helpers.
package xgriscv_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {DM_IDLE, DM_ACCESS, DM_RESP} dm_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef enum logic [1:0] {AccByte, AccHalf, AccWord} acc_width_e;

    // Undefined funct3 encodings collapse to word accesses.
    function automatic acc_width_e size_width(input logic [2:0] size);
        case (size)
            SZ_B, SZ_BU: return AccByte;
            SZ_H, SZ_HU: return AccHalf;
            default:     return AccWord;
        endcase
    endfunction

    function automatic logic size_illegal(input logic [2:0] size);
        return (size == 3'b011) || (size == 3'b110) || (size == 3'b111);
    endfunction

endpackage

// File: rtl/dmem_ld_align.sv
// Load formatting: shifts the RAM word down to the addressed byte/half and
// sign- or zero-extends it according to funct3.
module dmem_ld_align
    import xgriscv_pkg::*;
(
    input  logic [31:0] mem_rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  size_i,
    output logic [31:0] rdata_o
);

    acc_width_e  width;
    logic [1:0]  offset;
    logic [31:0] shifted;
    logic        sext;

    always_comb begin
        width   = size_width(size_i);
        sext    = ~size_i[2];
        offset  = 2'b00;
        case (width)
            AccByte: offset = addr_lo_i;
            AccHalf: offset = {addr_lo_i[1], 1'b0};
            default: offset = 2'b00;
        endcase
        shifted = mem_rdata_i >> {offset, 3'b000};
        case (width)
            AccByte: rdata_o = {{24{sext & shifted[7]}}, shifted[7:0]};
            AccHalf: rdata_o = {{16{sext & shifted[15]}}, shifted[15:0]};
            default: rdata_o = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one synchronous-read data RAM between the CPU and loader ports with
// round-robin arbitration and RISC-V sub-word formatting.
// Optional misalignment trapping is enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_arbiter
    import xgriscv_pkg::*;
#(
    parameter int unsigned MEM_AW = 10
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [31:0]       c_addr,
    input  logic [2:0]        c_size,
    input  logic [31:0]       c_wdata,
    output logic              c_ack,
    output logic [31:0]       c_rdata,
    output logic              c_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [2:0]        d_size,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    dm_state_e         state_q;
    logic              last_grant_q;
    logic              win_q;
    logic              we_q;
    logic              bad_q;
    logic [1:0]        addr_lo_q;
    logic [2:0]        size_q;
    logic              mem_en_q;
    logic [3:0]        mem_we_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              c_ack_q, d_ack_q, c_err_q, d_err_q;
    logic [31:0]       c_hold_q, d_hold_q;

    logic              grant;
    logic              sel_we;
    logic [31:0]       sel_addr;
    logic [2:0]        sel_size;
    logic [31:0]       sel_wdata;
    logic [3:0]        st_be;
    logic [31:0]       st_data;
    logic              sel_bad;
    acc_width_e        sel_width;
    logic [31:0]       aligned;
    logic [31:0]       ld_data;
    logic              c_ld_ack, d_ld_ack;

    always_comb begin
        if (c_req && d_req) begin
            grant = ~last_grant_q;
        end else begin
            grant = c_req ? PORT_CPU : PORT_DBG;
        end
        sel_we    = (grant == PORT_CPU) ? c_we    : d_we;
        sel_addr  = (grant == PORT_CPU) ? c_addr  : d_addr;
        sel_size  = (grant == PORT_CPU) ? c_size  : d_size;
        sel_wdata = (grant == PORT_CPU) ? c_wdata : d_wdata;
        sel_width = size_width(sel_size);
        case (sel_width)
            AccByte: begin
                st_be   = 4'b0001 << sel_addr[1:0];
                st_data = {4{sel_wdata[7:0]}};
            end
            AccHalf: begin
                st_be   = 4'b0011 << {sel_addr[1], 1'b0};
                st_data = {2{sel_wdata[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = sel_wdata;
            end
        endcase
`ifdef DMEM_MISALIGN_TRAP_EN
        sel_bad = size_illegal(sel_size)
                | ((sel_width == AccHalf) && sel_addr[0])
                | ((sel_width == AccWord) && (sel_addr[1:0] != 2'b00));
`else
        sel_bad = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= DM_IDLE;
            last_grant_q <= PORT_DBG;
            win_q        <= PORT_CPU;
            we_q         <= 1'b0;
            bad_q        <= 1'b0;
            addr_lo_q    <= 2'b00;
            size_q       <= 3'b000;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 4'b0000;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
            c_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            c_err_q      <= 1'b0;
            d_err_q      <= 1'b0;
            c_hold_q     <= 32'h0;
            d_hold_q     <= 32'h0;
        end else begin
            case (state_q)
                DM_IDLE: begin
                    if (c_req || d_req) begin
                        state_q      <= DM_ACCESS;
                        last_grant_q <= grant;
                        win_q        <= grant;
                        we_q         <= sel_we;
                        bad_q        <= sel_bad;
                        addr_lo_q    <= sel_addr[1:0];
                        size_q       <= sel_size;
                        mem_en_q     <= ~sel_bad;
                        mem_we_q     <= (sel_we && !sel_bad) ? st_be : 4'b0000;
                        mem_addr_q   <= sel_addr[MEM_AW+1:2];
                        mem_wdata_q  <= st_data;
                    end
                end
                DM_ACCESS: begin
                    state_q  <= DM_RESP;
                    mem_en_q <= 1'b0;
                    mem_we_q <= 4'b0000;
                    c_ack_q  <= (win_q == PORT_CPU);
                    d_ack_q  <= (win_q == PORT_DBG);
                    c_err_q  <= (win_q == PORT_CPU) && bad_q;
                    d_err_q  <= (win_q == PORT_DBG) && bad_q;
                end
                DM_RESP: begin
                    state_q <= DM_IDLE;
                    c_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                    c_err_q <= 1'b0;
                    d_err_q <= 1'b0;
                    if (c_ld_ack) c_hold_q <= ld_data;
                    if (d_ld_ack) d_hold_q <= ld_data;
                end
                default: state_q <= DM_IDLE;
            endcase
        end
    end

    dmem_ld_align u_ld_align (
        .mem_rdata_i (mem_rdata),
        .addr_lo_i   (addr_lo_q),
        .size_i      (size_q),
        .rdata_o     (aligned)
    );

    // RAM data only arrives in RESP, so the acked rdata is combinational and
    // a holding register keeps it afterwards. Trapped accesses return zero.
    always_comb begin
        ld_data  = bad_q ? 32'h0 : aligned;
        c_ld_ack = c_ack_q && (!we_q || bad_q);
        d_ld_ack = d_ack_q && (!we_q || bad_q);
    end

    assign c_rdata   = c_ld_ack ? ld_data : c_hold_q;
    assign d_rdata   = d_ld_ack ? ld_data : d_hold_q;
    assign c_ack     = c_ack_q;
    assign d_ack     = d_ack_q;
    assign c_err     = c_err_q;
    assign d_err     = d_err_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural byte-writable RAM model.
module tb_dmem_arbiter;

    logic        clk, rstn;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic [2:0]  c_size, d_size;
    logic        c_ack, c_err, d_ack, d_err;
    logic [31:0] c_rdata, d_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] ram [0:1023];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] lw06_exp;

    dmem_arbiter #(.MEM_AW(10)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .c_req     (c_req),
        .c_we      (c_we),
        .c_addr    (c_addr),
        .c_size    (c_size),
        .c_wdata   (c_wdata),
        .c_ack     (c_ack),
        .c_rdata   (c_rdata),
        .c_err     (c_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_size    (d_size),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One CPU access from IDLE: checks the RAM strobe cycle, then the ack cycle.
    task automatic cpu_op(input string tag, input logic we, input logic [31:0] addr,
                          input logic [2:0] size, input logic [31:0] wdata,
                          input logic exp_en, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [31:0] exp_rd,
                          input logic exp_err);
        logic [31:0] exp_ma;
        exp_ma = {22'd0, addr[11:2]};
        @(negedge clk);
        c_req = 1'b1; c_we = we; c_addr = addr; c_size = size; c_wdata = wdata;
        @(negedge clk);
        check_eq({tag, ".mem_en"}, {31'd0, mem_en}, {31'd0, exp_en});
        if (exp_en) begin
            check_eq({tag, ".mem_addr"}, {22'd0, mem_addr}, exp_ma);
            check_eq({tag, ".mem_we"}, {28'd0, mem_we}, {28'd0, exp_be});
            if (we) check_eq({tag, ".mem_wdata"}, mem_wdata, exp_wd);
        end
        check_eq({tag, ".early_ack"}, {31'd0, c_ack}, 32'd0);
        @(negedge clk);
        check_eq({tag, ".c_ack"}, {31'd0, c_ack}, 32'd1);
        check_eq({tag, ".d_ack"}, {31'd0, d_ack}, 32'd0);
        check_eq({tag, ".c_err"}, {31'd0, c_err}, {31'd0, exp_err});
        if (!we || exp_err) check_eq({tag, ".c_rdata"}, c_rdata, exp_rd);
        c_req = 1'b0;
    endtask

    initial begin
        clk = 1'b0; rstn = 1'b0;
        c_req = 0; c_we = 0; c_addr = 0; c_size = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_size = 0; d_wdata = 0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst.mem_en", {31'd0, mem_en}, 32'd0);
        check_eq("rst.mem_we", {28'd0, mem_we}, 32'd0);
        check_eq("rst.c_ack", {31'd0, c_ack}, 32'd0);
        check_eq("rst.d_ack", {31'd0, d_ack}, 32'd0);
        check_eq("rst.c_rdata", c_rdata, 32'd0);
        rstn = 1'b1;

        cpu_op("sw10", 1'b1, 32'h10, 3'b010, 32'hF1F2F3F4, 1'b1, 4'b1111, 32'hF1F2F3F4, 32'h0, 1'b0);
        cpu_op("lb13", 1'b0, 32'h13, 3'b000, 32'h0, 1'b1, 4'b0000, 32'h0, 32'hFFFFFFF1, 1'b0);
        cpu_op("lbu13", 1'b0, 32'h13, 3'b100, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h000000F1, 1'b0);
        cpu_op("lh10", 1'b0, 32'h10, 3'b001, 32'h0, 1'b1, 4'b0000, 32'h0, 32'hFFFFF3F4, 1'b0);
        cpu_op("lhu12", 1'b0, 32'h12, 3'b101, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0000F1F2, 1'b0);
        cpu_op("sb11", 1'b1, 32'h11, 3'b000, 32'h000000A5, 1'b1, 4'b0010, 32'hA5A5A5A5, 32'h0, 1'b0);
        cpu_op("lw10", 1'b0, 32'h10, 3'b010, 32'h0, 1'b1, 4'b0000, 32'h0, 32'hF1F2A5F4, 1'b0);
        cpu_op("sh16", 1'b1, 32'h16, 3'b001, 32'h00001234, 1'b1, 4'b1100, 32'h12341234, 32'h0, 1'b0);
        cpu_op("lh16", 1'b0, 32'h16, 3'b001, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h00001234, 1'b0);
        cpu_op("sw04", 1'b1, 32'h04, 3'b010, 32'h11223344, 1'b1, 4'b1111, 32'h11223344, 32'h0, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
        lw06_exp = 32'h0;
        cpu_op("lw06", 1'b0, 32'h06, 3'b010, 32'h0, 1'b0, 4'b0000, 32'h0, lw06_exp, 1'b1);
`else
        lw06_exp = 32'h11223344;
        cpu_op("lw06", 1'b0, 32'h06, 3'b010, 32'h0, 1'b1, 4'b0000, 32'h0, lw06_exp, 1'b0);
`endif
        @(negedge clk);
        check_eq("hold.c_rdata", c_rdata, lw06_exp);
        check_eq("hold.c_ack", {31'd0, c_ack}, 32'd0);

        // Reset asserted while the access is in ACCESS.
        @(negedge clk);
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10; c_size = 3'b010;
        @(negedge clk);
        check_eq("mrst.pre_en", {31'd0, mem_en}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        check_eq("mrst.mem_en", {31'd0, mem_en}, 32'd0);
        check_eq("mrst.mem_addr", {22'd0, mem_addr}, 32'd0);
        check_eq("mrst.c_rdata", c_rdata, 32'd0);
        @(negedge clk);
        check_eq("mrst.c_ack", {31'd0, c_ack}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check_eq("mrst.regrant_en", {31'd0, mem_en}, 32'd1);
        check_eq("mrst.regrant_ack0", {31'd0, c_ack}, 32'd0);
        @(negedge clk);
        check_eq("mrst.ack", {31'd0, c_ack}, 32'd1);
        check_eq("mrst.rdata", c_rdata, 32'hF1F2A5F4);
        c_req = 1'b0;

        // Round-robin: both ports held high from reset release.
        @(negedge clk);
        rstn = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_size = 3'b010;
        c_req = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check_eq($sformatf("rr.c_ack%0d", k), {31'd0, c_ack},
                     {31'd0, (k == 2) || (k == 8)});
            check_eq($sformatf("rr.d_ack%0d", k), {31'd0, d_ack}, {31'd0, k == 5});
            if (k == 5) check_eq("rr.d_rdata", d_rdata, 32'hF1F2A5F4);
        end
        c_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rr.idle_en", {31'd0, mem_en}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
